// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/hazard controller slice.
package hazard_pkg;

  localparam int unsigned DEF_REG_AW  = 5;
  localparam int unsigned DEF_NUM_RD  = 2;
  localparam int unsigned DEF_NUM_FWD = 2;
  localparam int unsigned DEF_MUL_LAT = 3;

  localparam int unsigned SEL_RF   = 0;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // Forward-select code for pipeline stage k (0 = EX).
  function automatic int unsigned fwd_code(input int unsigned stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/pipeline-stage bundle seen by the hazard controller.
// Optional HAZ_STATS_EN adds the saturating statistics counters.
interface hazard_ctrl_if import hazard_pkg::*; #(
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned NUM_RD  = DEF_NUM_RD,
  parameter int unsigned NUM_FWD = DEF_NUM_FWD,
  parameter int unsigned SEL_W   = $clog2(NUM_FWD + 1)
);

  logic                      id_valid;
  logic [NUM_RD-1:0]         id_rd_en;
  logic [NUM_RD*REG_AW-1:0]  id_rd_addr;
  logic                      id_wr_en;
  logic [REG_AW-1:0]         id_wr_addr;
  logic                      id_is_mul;
  logic [NUM_FWD-1:0]        stg_wr_en;
  logic [NUM_FWD*REG_AW-1:0] stg_wr_addr;
  logic [NUM_FWD-1:0]        stg_is_load;

  logic [NUM_RD*SEL_W-1:0]   fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic                      mul_busy;
  logic                      mul_done;
`ifdef HAZ_STATS_EN
  logic [31:0]               stat_loaduse;
  logic [31:0]               stat_mulstall;
  logic [31:0]               stat_fwd;
`endif

  modport master (
    output id_valid, id_rd_en, id_rd_addr, id_wr_en, id_wr_addr, id_is_mul,
    output stg_wr_en, stg_wr_addr, stg_is_load,
`ifdef HAZ_STATS_EN
    input  stat_loaduse, stat_mulstall, stat_fwd,
`endif
    input  fwd_sel, stall, bubble, mul_busy, mul_done
  );

  modport slave (
    input  id_valid, id_rd_en, id_rd_addr, id_wr_en, id_wr_addr, id_is_mul,
    input  stg_wr_en, stg_wr_addr, stg_is_load,
`ifdef HAZ_STATS_EN
    output stat_loaduse, stat_mulstall, stat_fwd,
`endif
    output fwd_sel, stall, bubble, mul_busy, mul_done
  );

endinterface

// File: rtl/hazard_mul_tracker.sv
// Multicycle-multiply scoreboard: busy/countdown FSM, pending destination
// register and the RAW/WAW/structural stall compare against it.
module hazard_mul_tracker import hazard_pkg::*; #(
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned NUM_RD  = DEF_NUM_RD,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_RD-1:0]        id_rd_en,
  input  logic [NUM_RD*REG_AW-1:0] id_rd_addr,
  input  logic                     id_wr_en,
  input  logic [REG_AW-1:0]        id_wr_addr,
  input  logic                     id_is_mul,
  input  logic                     ext_stall,
  output logic                     mul_stall,
  output logic                     mul_busy,
  output logic                     mul_done
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MUL_LAT - 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] pend_q, pend_d;
  logic              done_q, done_d;

  logic raw_hit, waw_hit, struct_hit, pend_live, issue;

  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (id_rd_en[p] && id_rd_addr[p*REG_AW +: REG_AW] == pend_q)
        raw_hit = 1'b1;
    end
  end

  // The final (count 0) cycle writes back through the regfile bypass, so the
  // pending-register compare is only live while the count is non-zero.
  assign pend_live  = (state_q == BUSY) && (cnt_q != '0) &&
                      (pend_q != REG_AW'(REG_ZERO));
  assign waw_hit    = id_wr_en && (id_wr_addr == pend_q);
  assign struct_hit = (state_q == BUSY) && (cnt_q != '0) && id_is_mul;

  assign mul_stall = id_valid && ((pend_live && (raw_hit || waw_hit)) || struct_hit);
  assign issue     = id_valid && id_is_mul && !mul_stall && !ext_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = CNT_RELOAD;
          pend_d  = id_wr_addr;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          done_d = (cnt_q == CNT_W'(1));
        end else if (issue) begin
          cnt_d  = CNT_RELOAD;
          pend_d = id_wr_addr;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign mul_busy = (state_q == BUSY);
  assign mul_done = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding-select, load-use and multiply hazard controller beside the ID decoder.
// Optional HAZ_STATS_EN adds saturating stall/forward statistics counters.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned NUM_RD  = DEF_NUM_RD,
  parameter int unsigned NUM_FWD = DEF_NUM_FWD,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  logic                    active;
  logic [SEL_W-1:0]        sel_arr [NUM_RD];
  logic                    lu_arr  [NUM_RD];
  logic [NUM_RD*SEL_W-1:0] fwd_flat;
  logic                    load_use;
  logic                    mul_stall;

  assign active = bus.id_valid && !rst;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [REG_AW-1:0] ra;
    logic [SEL_W-1:0]  sel;
    logic              lu, fwd_found, shadowed, seen_load;

    assign ra = bus.id_rd_addr[p*REG_AW +: REG_AW];

    // Walk stages youngest first: the first non-load match forwards, and only
    // the youngest load stage can raise load-use, unless a younger match shadows it.
    always_comb begin
      sel       = SEL_W'(SEL_RF);
      lu        = 1'b0;
      fwd_found = 1'b0;
      shadowed  = 1'b0;
      seen_load = 1'b0;
      if (active && bus.id_rd_en[p] && ra != REG_AW'(REG_ZERO)) begin
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
          if (bus.stg_wr_en[k] && bus.stg_is_load[k]) begin
            if (!seen_load && !shadowed &&
                bus.stg_wr_addr[k*REG_AW +: REG_AW] == ra)
              lu = 1'b1;
            seen_load = 1'b1;
          end else if (bus.stg_wr_en[k] &&
                       bus.stg_wr_addr[k*REG_AW +: REG_AW] == ra) begin
            shadowed = 1'b1;
            if (!fwd_found) begin
              sel       = SEL_W'(fwd_code(k));
              fwd_found = 1'b1;
            end
          end
        end
      end
    end

    assign sel_arr[p] = sel;
    assign lu_arr[p]  = lu;
  end

  always_comb begin
    fwd_flat = '0;
    load_use = 1'b0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      fwd_flat[p*SEL_W +: SEL_W] = sel_arr[p];
      load_use = load_use | lu_arr[p];
    end
  end

  hazard_mul_tracker #(
    .REG_AW  (REG_AW),
    .NUM_RD  (NUM_RD),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (active),
    .id_rd_en   (bus.id_rd_en),
    .id_rd_addr (bus.id_rd_addr),
    .id_wr_en   (bus.id_wr_en),
    .id_wr_addr (bus.id_wr_addr),
    .id_is_mul  (bus.id_is_mul),
    .ext_stall  (load_use),
    .mul_stall  (mul_stall),
    .mul_busy   (bus.mul_busy),
    .mul_done   (bus.mul_done)
  );

  assign bus.fwd_sel = fwd_flat;
  assign bus.stall   = load_use || mul_stall;
  assign bus.bubble  = load_use || mul_stall;

`ifdef HAZ_STATS_EN
  logic [31:0] st_lu_q, st_ms_q, st_fw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_lu_q <= '0;
      st_ms_q <= '0;
      st_fw_q <= '0;
    end else begin
      if (load_use && st_lu_q != '1)
        st_lu_q <= st_lu_q + 32'd1;
      if (mul_stall && st_ms_q != '1)
        st_ms_q <= st_ms_q + 32'd1;
      if ((|fwd_flat) && st_fw_q != '1)
        st_fw_q <= st_fw_q + 32'd1;
    end
  end

  assign bus.stat_loaduse  = st_lu_q;
  assign bus.stat_mulstall = st_ms_q;
  assign bus.stat_fwd      = st_fw_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: forwarding priority, load-use, multiply
// tracking, back-to-back issue, async reset and a randomised forwarding sweep.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .NUM_RD(2), .NUM_FWD(2), .SEL_W(2)) bus ();

  hazard_ctrl #(
    .REG_AW  (5),
    .NUM_RD  (2),
    .NUM_FWD (2),
    .MUL_LAT (3),
    .SEL_W   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [1:0] rd_en;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic       wr_en;
    logic [4:0] wa;
    logic       is_mul;
    logic [1:0] swe;
    logic [4:0] sa0;
    logic [4:0] sa1;
    logic [1:0] sld;
  } stim_t;

  typedef struct packed {
    logic [127:0] name;
    logic [7:0]   v;      // {fwd_sel[3:0], stall, bubble, mul_busy, mul_done}
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } step_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic stim_t S(input logic r, input logic v, input logic [1:0] re,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic we, input logic [4:0] wa, input logic m,
                              input logic [1:0] swe, input logic [4:0] s0,
                              input logic [4:0] s1, input logic [1:0] ld);
    stim_t x;
    x.rst = r; x.valid = v; x.rd_en = re; x.ra0 = a0; x.ra1 = a1;
    x.wr_en = we; x.wa = wa; x.is_mul = m;
    x.swe = swe; x.sa0 = s0; x.sa1 = s1; x.sld = ld;
    return x;
  endfunction

  function automatic step_t T(input logic [127:0] n, input stim_t s,
                              input logic [3:0] f, input logic st,
                              input logic b, input logic d);
    step_t r;
    r.s      = s;
    r.e.name = n;
    r.e.v    = {f, st, st, b, d};
    return r;
  endfunction

  function automatic logic [7:0] obs();
    return {bus.fwd_sel, bus.stall, bus.bubble, bus.mul_busy, bus.mul_done};
  endfunction

  task automatic apply(input stim_t s);
    rst             = s.rst;
    bus.id_valid    = s.valid;
    bus.id_rd_en    = s.rd_en;
    bus.id_rd_addr  = {s.ra1, s.ra0};
    bus.id_wr_en    = s.wr_en;
    bus.id_wr_addr  = s.wa;
    bus.id_is_mul   = s.is_mul;
    bus.stg_wr_en   = s.swe;
    bus.stg_wr_addr = {s.sa1, s.sa0};
    bus.stg_is_load = s.sld;
  endtask

  // Independent reference for the idle-tracker case: oldest-to-youngest
  // overwrite for forwarding, explicit youngest-load search for load-use.
  function automatic logic [7:0] model(input stim_t s);
    logic [1:0] sel [2];
    logic [4:0] sa [2];
    logic [4:0] ra;
    logic       lu, blocked;
    int         kl;
    sa[0] = s.sa0; sa[1] = s.sa1;
    lu = 1'b0;
    for (int p = 0; p < 2; p++) begin
      ra = (p == 0) ? s.ra0 : s.ra1;
      sel[p] = 2'd0;
      if (!s.rst && s.valid && s.rd_en[p] && ra != 5'd0) begin
        for (int k = 1; k >= 0; k--)
          if (s.swe[k] && !s.sld[k] && sa[k] == ra) sel[p] = 2'(k + 1);
        kl = -1;
        for (int k = 1; k >= 0; k--)
          if (s.swe[k] && s.sld[k]) kl = k;
        if (kl >= 0 && sa[kl] == ra) begin
          blocked = 1'b0;
          for (int k = 0; k < kl; k++)
            if (s.swe[k] && sa[k] == ra) blocked = 1'b1;
          if (!blocked) lu = 1'b1;
        end
      end
    end
    return {sel[1], sel[0], lu, lu, 2'b00};
  endfunction

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    logic [7:0] o;
    st.push_back(T("rst_held", S(1,1,2'b11,5,5,1,9,1,2'b11,5,5,2'b00), 4'h0,0,0,0));
    st.push_back(T("rst_released", S(0,0,2'b00,0,0,0,0,0,2'b00,0,0,2'b00), 4'h0,0,0,0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i].s);
      sb.push_back(st[i].e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_fwd_priority();
    step_t st[$];
    exp_t  e;
    logic [7:0] o;
    st.push_back(T("fwd_ex_wins",   S(0,1,2'b01,5,0,0,0,0,2'b11,5,5,2'b00), 4'b0001,0,0,0));
    st.push_back(T("fwd_mem_only",  S(0,1,2'b01,5,0,0,0,0,2'b10,5,5,2'b00), 4'b0010,0,0,0));
    st.push_back(T("fwd_both_ports",S(0,1,2'b11,5,5,0,0,0,2'b11,5,5,2'b00), 4'b0101,0,0,0));
    st.push_back(T("fwd_invalid",   S(0,0,2'b11,5,5,0,0,0,2'b11,5,5,2'b00), 4'b0000,0,0,0));
    st.push_back(T("fwd_port_off",  S(0,1,2'b00,5,5,0,0,0,2'b11,5,5,2'b00), 4'b0000,0,0,0));
    st.push_back(T("fwd_split",     S(0,1,2'b11,6,5,0,0,0,2'b11,5,6,2'b00), 4'b0110,0,0,0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i].s);
      sb.push_back(st[i].e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_zero_reg();
    step_t st[$];
    exp_t  e;
    logic [7:0] o;
    st.push_back(T("zero_fwd",  S(0,1,2'b11,0,0,0,0,0,2'b11,0,0,2'b00), 4'h0,0,0,0));
    st.push_back(T("zero_load", S(0,1,2'b11,0,0,0,0,0,2'b01,0,0,2'b01), 4'h0,0,0,0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i].s);
      sb.push_back(st[i].e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    exp_t  e;
    logic [7:0] o;
    st.push_back(T("lu_ex_load",     S(0,1,2'b10,3,8,0,0,0,2'b01,8,0,2'b01), 4'b0000,1,0,0));
    st.push_back(T("lu_mem_still",   S(0,1,2'b10,3,8,0,0,0,2'b10,0,8,2'b10), 4'b0000,1,0,0));
    st.push_back(T("lu_mem_ready",   S(0,1,2'b10,3,8,0,0,0,2'b10,0,8,2'b00), 4'b1000,0,0,0));
    st.push_back(T("lu_shadowed",    S(0,1,2'b10,3,8,0,0,0,2'b11,8,8,2'b10), 4'b0100,0,0,0));
    st.push_back(T("lu_ex_over_mem", S(0,1,2'b01,3,0,0,0,0,2'b11,3,3,2'b01), 4'b0010,1,0,0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i].s);
      sb.push_back(st[i].e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_mul_raw();
    step_t st[$];
    exp_t  e;
    logic [7:0] o;
    st.push_back(T("mul_issue",    S(0,1,2'b00,0,0,1,9,1,2'b00,0,0,2'b00), 4'h0,0,0,0));
    st.push_back(T("mul_raw_c1",   S(0,1,2'b01,9,0,0,0,0,2'b00,0,0,2'b00), 4'h0,1,1,0));
    st.push_back(T("mul_waw_c2",   S(0,1,2'b00,0,0,1,9,0,2'b00,0,0,2'b00), 4'h0,1,1,0));
    st.push_back(T("mul_done_rel", S(0,1,2'b01,9,0,0,0,0,2'b00,0,0,2'b00), 4'h0,0,1,1));
    st.push_back(T("mul_idle",     S(0,0,2'b00,0,0,0,0,0,2'b00,0,0,2'b00), 4'h0,0,0,0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i].s);
      sb.push_back(st[i].e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    logic [7:0] o;
    st.push_back(T("b2b_issue1",   S(0,1,2'b00,0,0,1,9,1,2'b00,0,0,2'b00),  4'h0,0,0,0));
    st.push_back(T("b2b_struct1",  S(0,1,2'b00,0,0,1,10,1,2'b00,0,0,2'b00), 4'h0,1,1,0));
    st.push_back(T("b2b_struct2",  S(0,1,2'b00,0,0,1,10,1,2'b00,0,0,2'b00), 4'h0,1,1,0));
    st.push_back(T("b2b_issue2",   S(0,1,2'b00,0,0,1,10,1,2'b00,0,0,2'b00), 4'h0,0,1,1));
    st.push_back(T("b2b_raw_new",  S(0,1,2'b01,10,0,0,0,0,2'b00,0,0,2'b00), 4'h0,1,1,0));
    st.push_back(T("b2b_old_free", S(0,1,2'b01,9,0,0,0,0,2'b00,0,0,2'b00),  4'h0,0,1,0));
    st.push_back(T("b2b_done2",    S(0,0,2'b00,0,0,0,0,0,2'b00,0,0,2'b00),  4'h0,0,1,1));
    st.push_back(T("b2b_idle",     S(0,0,2'b00,0,0,0,0,0,2'b00,0,0,2'b00),  4'h0,0,0,0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i].s);
      sb.push_back(st[i].e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t st[$];
    exp_t  e;
    logic [7:0] o;
    st.push_back(T("rm_issue",    S(0,1,2'b00,0,0,1,9,1,2'b00,0,0,2'b00), 4'h0,0,0,0));
    st.push_back(T("rm_busy",     S(0,0,2'b00,0,0,0,0,0,2'b00,0,0,2'b00), 4'h0,0,1,0));
    st.push_back(T("rm_cnt1",     S(0,1,2'b01,9,0,0,0,0,2'b00,0,0,2'b00), 4'h0,1,1,0));
    st.push_back(T("rm_async",    S(1,1,2'b01,9,0,0,0,0,2'b00,0,0,2'b00), 4'h0,0,0,0));
    st.push_back(T("rm_hold",     S(1,1,2'b01,9,0,0,0,0,2'b01,9,0,2'b00), 4'h0,0,0,0));
    st.push_back(T("rm_no_done",  S(0,1,2'b01,9,0,0,0,0,2'b00,0,0,2'b00), 4'h0,0,0,0));
    st.push_back(T("rm_quiet",    S(0,0,2'b00,0,0,0,0,0,2'b00,0,0,2'b00), 4'h0,0,0,0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i].s);
      sb.push_back(st[i].e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s: got %b expected %b", e.name, o, e.v);
      end
    end
`ifdef HAZ_STATS_EN
    n_cmp++;
    if ({bus.stat_loaduse, bus.stat_mulstall, bus.stat_fwd} !== 96'd0) begin
      n_bad++;
      $display("FAIL stats_after_rst: got %0d/%0d/%0d expected 0/0/0",
               bus.stat_loaduse, bus.stat_mulstall, bus.stat_fwd);
    end
    @(negedge clk);
    apply(S(0,1,2'b01,5,0,0,0,0,2'b01,5,0,2'b00));
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.stat_loaduse, bus.stat_mulstall, bus.stat_fwd} !== {32'd0, 32'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL stats_one_fwd: got %0d/%0d/%0d expected 0/0/1",
               bus.stat_loaduse, bus.stat_mulstall, bus.stat_fwd);
    end
`endif
  endtask

  task automatic test_random_fwd();
    stim_t s;
    exp_t  e;
    logic [7:0] o;
    for (int i = 0; i < 40; i++) begin
      s = S(0, ($urandom_range(0, 7) != 0), 2'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 0, 0, 0, 2'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom));
      @(negedge clk);
      apply(s);
      e.name = "rand_fwd";
      e.v    = model(s);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %0s[%0d]: got %b expected %b stim %h", e.name, i, o, e.v, s);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(S(1,0,2'b00,0,0,0,0,0,2'b00,0,0,2'b00));
    test_reset();
    test_fwd_priority();
    test_zero_reg();
    test_load_use();
    test_mul_raw();
    test_back_to_back();
    test_reset_mid();
    test_random_fwd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
